channels_decoder_fs: RTL and testbench

//  Next-gen RC receiver decoder: K_NCHAN PWM inputs (one pwm_capture each) routed to K_NFUNC functions.

---
 rtl/rc_decoder_pkg.sv | 16 +
 rtl/rc_chan_monitor.sv | 91 +++++++++
 rtl/channels_decoder_fs.sv | 206 ++++++++++++++++++++
 tb/tb_channels_decoder_fs.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc_decoder_pkg.sv
// Shared types for the RC channel decoder.
// Arm/failsafe states and routed-function indices.
package rc_decoder_pkg;

  typedef enum logic [1:0] {
    DISARMED,
    RUN,
    FAILSAFE
  } state_e;

  localparam int F_DIR   = 0;
  localparam int F_PWR   = 1;
  localparam int F_REV   = 2;
  localparam int F_OTHER = 3;

endpackage

// File: rtl/rc_chan_monitor.sv
// One RC input: PWM width capture, centring, deadzone
// classification and signal-loss watchdog.
module rc_chan_monitor #(
  parameter int K_RES = 10,
  parameter int K_TOW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pwm,
  input  logic [K_RES-1:0] i_skip,
  input  logic [K_RES-1:0] i_deadzone,
  input  logic             i_timebase,
  input  logic [K_TOW-1:0] i_timeout,
  output logic             o_done,
  output logic [K_RES-1:0] o_value,
  output logic             o_sign,
  output logic             o_neutral,
  output logic             o_pos,
  output logic             o_neg,
  output logic             o_lost
);

  localparam logic [K_RES-1:0] MIN_V = {1'b1, {(K_RES-1){1'b0}}};
  localparam logic [K_RES-1:0] MAX_V = {1'b0, {(K_RES-1){1'b1}}};

  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [K_RES-1:0] cnt_q, cnt_d;
  logic [K_TOW-1:0] wd_q, wd_d;
  logic             lost_q, lost_d;
  logic             rise, fall;
  logic [K_RES-1:0] v, mag;

  always_comb begin
    sync_d = {sync_q[0], i_pwm};
    prev_d = sync_q[1];
    rise   = sync_q[1] & ~prev_q;
    fall   = ~sync_q[1] & prev_q;
    cnt_d  = cnt_q;
    if (rise)
      cnt_d = K_RES'(1);
    else if (sync_q[1] && cnt_q != '1)
      cnt_d = cnt_q + K_RES'(1);
    o_done = fall && (cnt_q >= i_skip);
    // width minus mid-scale is just an MSB flip
    v = {~cnt_q[K_RES-1], cnt_q[K_RES-2:0]};
    if (!v[K_RES-1])
      mag = v;
    else if (v == MIN_V)
      mag = MAX_V;
    else
      mag = -v;
    o_neutral = mag < i_deadzone;
    o_value   = o_neutral ? '0 : v;
    o_sign    = v[K_RES-1];
    o_pos     = ~v[K_RES-1] & ~o_neutral;
    o_neg     = v[K_RES-1] & ~o_neutral;
  end

  always_comb begin
    wd_d   = wd_q;
    lost_d = lost_q;
    if (o_done) begin
      wd_d   = '0;
      lost_d = 1'b0;
    end else begin
      if (i_timebase && wd_q != '1)
        wd_d = wd_q + K_TOW'(1);
      lost_d = lost_q | ((i_timeout != '0) && (wd_d >= i_timeout));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      wd_q   <= '0;
      lost_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      wd_q   <= wd_d;
      lost_q <= lost_d;
    end
  end

  assign o_lost = lost_q;

endmodule

// File: rtl/channels_decoder_fs.sv
// RC receiver decoder: routing, debounced digital functions
// and the arm/failsafe state machine.
module channels_decoder_fs
  import rc_decoder_pkg::*;
#(
  parameter int K_NCHAN    = 4,
  parameter int K_NFUNC    = 4,
  parameter int K_RES      = 10,
  parameter int K_TOW      = 8,
  parameter int K_ARM_CAPT = 8,
  parameter int K_DEBOUNCE = 3,
  localparam int CW = (K_NCHAN > 1) ? $clog2(K_NCHAN) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [K_NFUNC-1:0][CW-1:0]  i_chan_route,
  input  logic [K_NCHAN-1:0]          i_channels,
  input  logic [K_NCHAN-1:0]          i_polarity,
  input  logic [K_RES-1:0]            i_deadzone,
  input  logic [K_RES-1:0]            i_skip_threshold,
  input  logic                        i_timebase,
  input  logic [K_TOW-1:0]            i_timeout,
  output logic [K_RES-1:0]            o_steer,
  output logic [K_RES-1:0]            o_power,
  output logic                        o_power_done,
  output logic                        o_direction,
  output logic                        o_brake,
  output logic                        o_rev,
  output logic                        o_boost,
  output logic                        o_beep,
  output logic [K_NCHAN-1:0]          o_chan_lost,
  output logic                        o_armed,
  output logic                        o_failsafe
);

  localparam int AW = $clog2(K_ARM_CAPT + 1);
  localparam int RW = $clog2(K_DEBOUNCE + 1);

  logic [K_NCHAN-1:0]            c_done, c_sign, c_neu, c_pos, c_neg;
  logic [K_NCHAN-1:0][K_RES-1:0] c_val;
  logic [K_NFUNC-1:0]            f_done, f_sign, f_neu, f_pos, f_neg, f_pol;
  logic [K_NFUNC-1:0][K_RES-1:0] f_val;
  logic                          routed_lost, route_chg, run_d;

  for (genvar c = 0; c < K_NCHAN; c++) begin : g_ch
    rc_chan_monitor #(.K_RES(K_RES), .K_TOW(K_TOW)) u_mon (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_pwm      (i_channels[c]),
      .i_skip     (i_skip_threshold),
      .i_deadzone (i_deadzone),
      .i_timebase (i_timebase),
      .i_timeout  (i_timeout),
      .o_done     (c_done[c]),
      .o_value    (c_val[c]),
      .o_sign     (c_sign[c]),
      .o_neutral  (c_neu[c]),
      .o_pos      (c_pos[c]),
      .o_neg      (c_neg[c]),
      .o_lost     (o_chan_lost[c])
    );
  end

  logic [K_NFUNC-1:0][CW-1:0] route_q;
  state_e                     state_q, state_d;
  logic [AW-1:0]              arm_q, arm_d;
  logic [3:0]                 deb_q, deb_d, dev, draw;
  logic [3:0][RW-1:0]         run_q, run_d4;
  logic [K_RES-1:0]           steer_q, steer_d, power_q, power_d;
  logic                       pdone_q, dir_q, dir_d, brake_q, brake_d;
  logic                       rev_q, boost_q, beep_q, armed_q, fs_q;

  always_comb begin
    routed_lost = 1'b0;
    for (int f = 0; f < K_NFUNC; f++) begin
      f_done[f] = c_done[i_chan_route[f]];
      f_val[f]  = c_val[i_chan_route[f]];
      f_sign[f] = c_sign[i_chan_route[f]];
      f_neu[f]  = c_neu[i_chan_route[f]];
      f_pos[f]  = c_pos[i_chan_route[f]];
      f_neg[f]  = c_neg[i_chan_route[f]];
      f_pol[f]  = i_polarity[i_chan_route[f]];
      routed_lost = routed_lost | o_chan_lost[i_chan_route[f]];
    end
    route_chg = i_chan_route != route_q;
  end

  // debouncers: 0=brake 1=rev 2=boost 3=beep
  always_comb begin
    dev  = {f_done[F_OTHER], f_done[F_OTHER], f_done[F_REV], f_done[F_PWR]};
    draw[0] = f_pol[F_PWR]   ? f_neg[F_PWR]   : f_pos[F_PWR];
    draw[1] = f_pol[F_REV]   ? f_pos[F_REV]   : f_neg[F_REV];
    draw[2] = f_pol[F_OTHER] ? f_pos[F_OTHER] : f_neg[F_OTHER];
    draw[3] = f_pol[F_OTHER] ? f_neg[F_OTHER] : f_pos[F_OTHER];
    deb_d  = deb_q;
    run_d4 = run_q;
    for (int d = 0; d < 4; d++) begin
      if (dev[d]) begin
        if (draw[d] == deb_q[d]) begin
          run_d4[d] = '0;
        end else if (run_q[d] == RW'(K_DEBOUNCE - 1)) begin
          deb_d[d]  = draw[d];
          run_d4[d] = '0;
        end else begin
          run_d4[d] = run_q[d] + RW'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    unique case (state_q)
      DISARMED: begin
        if (routed_lost || route_chg) begin
          arm_d = '0;
        end else if (f_done[F_PWR]) begin
          if (!f_neu[F_PWR]) begin
            arm_d = '0;
          end else if (arm_q == AW'(K_ARM_CAPT - 1)) begin
            state_d = RUN;
            arm_d   = '0;
          end else begin
            arm_d = arm_q + AW'(1);
          end
        end
      end
      RUN: begin
        if (routed_lost)
          state_d = FAILSAFE;
        if (route_chg)
          arm_d = '0;
      end
      FAILSAFE: begin
        arm_d = '0;
        if (!routed_lost)
          state_d = DISARMED;
      end
      default: state_d = DISARMED;
    endcase
  end

  // outputs follow the next state so loss forces safe values at once
  always_comb begin
    run_d   = state_d == RUN;
    steer_d = '0;
    power_d = '0;
    dir_d   = 1'b0;
    brake_d = 1'b1;
    if (run_d) begin
      steer_d = f_done[F_DIR] ? f_val[F_DIR] : steer_q;
      power_d = f_done[F_PWR] ? f_val[F_PWR] : power_q;
      dir_d   = f_done[F_DIR] ? f_sign[F_DIR] ^ f_pol[F_DIR] : dir_q;
      brake_d = deb_d[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      route_q <= '0;
      state_q <= DISARMED;
      arm_q   <= '0;
      deb_q   <= '0;
      run_q   <= '0;
      steer_q <= '0;
      power_q <= '0;
      pdone_q <= 1'b0;
      dir_q   <= 1'b0;
      brake_q <= 1'b1;
      rev_q   <= 1'b0;
      boost_q <= 1'b0;
      beep_q  <= 1'b0;
      armed_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      route_q <= i_chan_route;
      state_q <= state_d;
      arm_q   <= arm_d;
      deb_q   <= deb_d;
      run_q   <= run_d4;
      steer_q <= steer_d;
      power_q <= power_d;
      pdone_q <= f_done[F_PWR];
      dir_q   <= dir_d;
      brake_q <= brake_d;
      rev_q   <= run_d & deb_d[1];
      boost_q <= run_d & deb_d[2];
      beep_q  <= run_d & deb_d[3];
      armed_q <= run_d;
      fs_q    <= state_d == FAILSAFE;
    end
  end

  assign o_steer      = steer_q;
  assign o_power      = power_q;
  assign o_power_done = pdone_q;
  assign o_direction  = dir_q;
  assign o_brake      = brake_q;
  assign o_rev        = rev_q;
  assign o_boost      = boost_q;
  assign o_beep       = beep_q;
  assign o_armed      = armed_q;
  assign o_failsafe   = fs_q;

endmodule

// File: tb/tb_channels_decoder_fs.sv
// Scoreboard bench for channels_decoder_fs: directed PWM frames,
// power captures checked by a monitor, other outputs checked directly.
module tb_channels_decoder_fs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][1:0] route;
  logic [3:0]      chans, pol, lost;
  logic [9:0]      dz, skip, steer, power;
  logic [7:0]      tmo;
  logic            tb_auto, tb_man, auto_en, tick_w;
  logic            pdone, dir, brake, rev, boost, beep, armed, fs;

  assign tick_w = tb_auto | tb_man;

  channels_decoder_fs dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_chan_route     (route),
    .i_channels       (chans),
    .i_polarity       (pol),
    .i_deadzone       (dz),
    .i_skip_threshold (skip),
    .i_timebase       (tick_w),
    .i_timeout        (tmo),
    .o_steer          (steer),
    .o_power          (power),
    .o_power_done     (pdone),
    .o_direction      (dir),
    .o_brake          (brake),
    .o_rev            (rev),
    .o_boost          (boost),
    .o_beep           (beep),
    .o_chan_lost      (lost),
    .o_armed          (armed),
    .o_failsafe       (fs)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] pwr;
    logic       armed;
  } exp_t;
  exp_t sb[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor for power captures
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pdone) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL power_done: got unexpected pulse expected none");
      end else begin
        e = sb.pop_front();
        chk("power", 32'(power), 32'(e.pwr));
        chk("armed_at_power", 32'(armed), 32'(e.armed));
      end
    end
  end

  initial begin
    tb_auto = 1'b0;
    forever begin
      repeat (63) @(negedge clk);
      tb_auto = auto_en;
      @(negedge clk);
      tb_auto = 1'b0;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      tb_man = 1'b1;
      @(negedge clk);
      tb_man = 1'b0;
    end
  endtask

  task automatic pulse(int ch, int w);
    chans[ch] = 1'b1;
    repeat (w) @(negedge clk);
    chans[ch] = 1'b0;
  endtask

  task automatic frame(int w0, int w1, int w2, int w3,
                       logic [9:0] ep, logic ea);
    exp_t e;
    if (w1 > 0) begin
      e.pwr   = ep;
      e.armed = ea;
      sb.push_back(e);
    end
    fork
      begin if (w0 > 0) pulse(0, w0); end
      begin if (w1 > 0) pulse(1, w1); end
      begin if (w2 > 0) pulse(2, w2); end
      begin if (w3 > 0) pulse(3, w3); end
    join
    repeat (100) @(negedge clk);
  endtask

  int oth[6] = '{700, 700, 512, 700, 700, 700};

  initial begin
    chans   = '0;
    route   = {2'd3, 2'd2, 2'd1, 2'd0};
    pol     = 4'b1000;
    dz      = 10'd16;
    skip    = 10'd100;
    tmo     = 8'd20;
    auto_en = 1'b1;
    tb_man  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_lost", 32'(lost), 32'hF);
    chk("rst_brake", 32'(brake), 1);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_power", 32'(power), 0);
    chk("rst_steer", 32'(steer), 0);
    chk("rst_fs", 32'(fs), 0);
    repeat (6400) @(negedge clk);
    chk("idle_lost", 32'(lost), 32'hF);
    chk("idle_brake", 32'(brake), 1);
    chk("idle_armed", 32'(armed), 0);
    chk("idle_power", 32'(power), 0);

    // first frame only clears the lost flags
    frame(512, 512, 512, 512, 10'd0, 1'b0);
    chk("wake_lost", 32'(lost), 0);
    for (int i = 1; i < 8; i++)
      frame(512, 512, 512, 512, 10'd0, 1'b0);
    chk("pre_arm", 32'(armed), 0);
    frame(512, 512, 512, 512, 10'd0, 1'b1);
    chk("armed", 32'(armed), 1);
    frame(512, 600, 512, 512, 10'd88, 1'b1);
    chk("power_88", 32'(power), 32'd88);

    frame(505, 512, 512, 512, 10'd0, 1'b1);
    chk("steer_dz", 32'(steer), 0);
    frame(400, 512, 512, 512, 10'd0, 1'b1);
    chk("steer_neg", 32'(steer), 32'h390);
    chk("direction", 32'(dir), 1);

    for (int i = 0; i < 6; i++) begin
      frame(512, 512, 512, oth[i], 10'd0, 1'b1);
      chk($sformatf("boost_%0d", i), 32'(boost), 32'(i == 5));
    end
    chk("beep", 32'(beep), 0);
    chk("rev", 32'(rev), 0);

    frame(512, 0, 512, 512, 10'd0, 1'b0);
    chk("pwr_not_lost_yet", 32'(lost[1]), 0);
    chk("still_armed", 32'(armed), 1);
    repeat (3) frame(512, 0, 512, 512, 10'd0, 1'b0);
    chk("pwr_lost", 32'(lost[1]), 1);
    chk("failsafe", 32'(fs), 1);
    chk("fs_power", 32'(power), 0);
    chk("fs_brake", 32'(brake), 1);
    chk("fs_armed", 32'(armed), 0);

    frame(512, 512, 512, 512, 10'd0, 1'b0);
    chk("fs_exit", 32'(fs), 0);
    for (int i = 0; i < 7; i++)
      frame(512, 512, 512, 512, 10'd0, 1'b0);
    frame(512, 512, 512, 512, 10'd0, 1'b1);
    chk("rearmed", 32'(armed), 1);

    repeat (4) frame(512, 0, 512, 512, 10'd0, 1'b0);
    chk("failsafe2", 32'(fs), 1);
    for (int i = 0; i < 9; i++)
      frame(512, 700, 512, 512, 10'd0, 1'b0);
    chk("no_arm_700", 32'(armed), 0);
    chk("no_fs_700", 32'(fs), 0);

    auto_en = 1'b0;
    repeat (3) @(negedge clk);
    pulse(3, 200);
    repeat (10) @(negedge clk);
    chk("wd_clear", 32'(lost[3]), 0);
    tick(18);
    pulse(3, 200);
    @(negedge clk);
    tb_man = 1'b1;
    repeat (2) @(negedge clk);
    tb_man = 1'b0;
    repeat (5) @(negedge clk);
    chk("wd_coincident", 32'(lost[3]), 0);
    tick(19);
    repeat (2) @(negedge clk);
    chk("wd_19", 32'(lost[3]), 0);
    tick(1);
    repeat (2) @(negedge clk);
    chk("wd_20", 32'(lost[3]), 1);
    tmo = 8'd0;
    pulse(3, 200);
    repeat (10) @(negedge clk);
    chk("wd_off_clear", 32'(lost[3]), 0);
    tick(40);
    repeat (2) @(negedge clk);
    chk("wd_off", 32'(lost[3]), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
